dispense_sequencer: RTL

//  Sequences one beverage dispense cycle after the drink selector has settled a choice.

---
 rtl/dispense_sequencer_pkg.sv | 36 +++
 rtl/phase_timer.sv | 36 +++
 rtl/dispense_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dispense_sequencer_pkg.sv
// Shared types for the beverage dispense sequencer:
// state codes, selection bundle and phase-length defaults.
package dispense_sequencer_pkg;

  localparam int unsigned T_HEAT_DEF = 3;
  localparam int unsigned T_BASE_DEF = 5;
  localparam int unsigned T_MIX_DEF  = 3;
  localparam int unsigned T_FLAV_DEF = 2;
  localparam int unsigned CW_DEF     = 4;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_HEAT  = 4'd1,
    S_BASE  = 4'd2,
    S_MIX   = 4'd3,
    S_FLAV  = 4'd4,
    S_DONE  = 4'd5,
    S_ERROR = 4'd6
  } state_e;

  typedef struct packed {
    logic cafe;
    logic te;
    logic leche;
    logic agua;
    logic vainilla;
    logic nada;
  } sel_t;

  function automatic logic sel_ok(input sel_t s);
    return (s.cafe ^ s.te)
         && !(s.leche && s.agua)
         && !(s.vainilla && s.nada);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase down-counter: loads a phase length, counts TICKs,
// flags EXPIRE on the TICK that ends the phase.
module phase_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          LOAD,
  input  logic [CW-1:0] LVAL,
  input  logic          TICK,
  output logic          EXPIRE
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load wins over a same-cycle TICK
  always_comb begin
    cnt_d = cnt_q;
    if (LOAD) begin
      cnt_d = LVAL;
    end else if (TICK && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign EXPIRE = TICK && (cnt_q == CW'(1));

endmodule

// File: rtl/dispense_sequencer.sv
// Beverage dispense sequencer: latches a drink selection on START
// and steps heater/valves through timed HEAT, BASE, MIX, FLAV phases.
module dispense_sequencer
  import dispense_sequencer_pkg::*;
#(
  parameter int unsigned T_HEAT = T_HEAT_DEF,
  parameter int unsigned T_BASE = T_BASE_DEF,
  parameter int unsigned T_MIX  = T_MIX_DEF,
  parameter int unsigned T_FLAV = T_FLAV_DEF,
  parameter int unsigned CW     = CW_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK,
  input  logic       START,
  input  logic       ABORT,
  input  logic       Cafe,
  input  logic       Te,
  input  logic       Leche,
  input  logic       Agua,
  input  logic       Vainilla,
  input  logic       Nada,
  output logic       HEATER,
  output logic       V_CAFE,
  output logic       V_TE,
  output logic       V_LECHE,
  output logic       V_AGUA,
  output logic       V_VAINILLA,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [3:0] Sactual
);

  state_e        state_q, state_d;
  sel_t          sel_q, sel_d;
  sel_t          sel_in;
  logic          load;
  logic [CW-1:0] lval;
  logic          expire;
  logic          has_mix;
  logic          has_flav;

  assign sel_in   = {Cafe, Te, Leche, Agua, Vainilla, Nada};
  assign has_mix  = sel_q.leche | sel_q.agua;
  assign has_flav = sel_q.vainilla & ~sel_q.nada;

  phase_timer #(
    .CW(CW)
  ) u_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .LOAD  (load),
    .LVAL  (lval),
    .TICK  (TICK),
    .EXPIRE(expire)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    load    = 1'b0;
    lval    = '0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          sel_d = sel_in;
          if (sel_ok(sel_in)) begin
            state_d = S_HEAT;
            load    = 1'b1;
            lval    = CW'(T_HEAT);
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_HEAT: begin
        if (expire) begin
          state_d = S_BASE;
          load    = 1'b1;
          lval    = CW'(T_BASE);
        end
      end
      S_BASE: begin
        if (expire) begin
          if (has_mix) begin
            state_d = S_MIX;
            load    = 1'b1;
            lval    = CW'(T_MIX);
          end else if (has_flav) begin
            state_d = S_FLAV;
            load    = 1'b1;
            lval    = CW'(T_FLAV);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_MIX: begin
        if (expire) begin
          if (has_flav) begin
            state_d = S_FLAV;
            load    = 1'b1;
            lval    = CW'(T_FLAV);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FLAV: begin
        if (expire) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides any phase advance, including one on this TICK
    if (ABORT && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      load    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    HEATER     = 1'b0;
    V_CAFE     = 1'b0;
    V_TE       = 1'b0;
    V_LECHE    = 1'b0;
    V_AGUA     = 1'b0;
    V_VAINILLA = 1'b0;
    DONE       = 1'b0;
    ERR        = 1'b0;
    case (state_q)
      S_HEAT: HEATER = 1'b1;
      S_BASE: begin
        HEATER = 1'b1;
        V_CAFE = sel_q.cafe;
        V_TE   = sel_q.te;
      end
      S_MIX: begin
        V_LECHE = sel_q.leche;
        V_AGUA  = sel_q.agua;
      end
      S_FLAV:  V_VAINILLA = 1'b1;
      S_DONE:  DONE = 1'b1;
      S_ERROR: ERR = 1'b1;
      default: ;
    endcase
  end

  assign BUSY    = (state_q != S_IDLE);
  assign Sactual = state_q;

endmodule
